// File: rtl/seg_display_pkg.sv
// Shared constants for the four-digit score / difficulty-banner display controller:
// active-low glyph codes {g,f,e,d,c,b,a}, letter codes, converter state enum.
package seg_display_pkg;

  localparam int SCORE_MAX = 9999;
  localparam int BCD_ITER  = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_S     = 7'b0010010;
  localparam logic [6:0] GLYPH_Y     = 7'b0010001;
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_R     = 7'b0101111;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  // Letter selectors used on the glyph decoder's code input when is_letter=1
  localparam logic [3:0] LTR_E = 4'd0;
  localparam logic [3:0] LTR_A = 4'd1;
  localparam logic [3:0] LTR_S = 4'd2;
  localparam logic [3:0] LTR_Y = 4'd3;
  localparam logic [3:0] LTR_H = 4'd4;
  localparam logic [3:0] LTR_R = 4'd5;
  localparam logic [3:0] LTR_D = 4'd6;

  // Bits needed to hold a banner down-counter loaded with n
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seg_display_ctrl_glyph.sv
// Combinational glyph decoder: digit or letter code to active-low 7-segment pattern.
module seg_glyph
  import seg_display_pkg::*;
(
  input  logic       is_letter,
  input  logic       blank,
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    if (!blank) begin
      if (is_letter) begin
        case (code)
          LTR_E:   seg = GLYPH_E;
          LTR_A:   seg = GLYPH_A;
          LTR_S:   seg = GLYPH_S;
          LTR_Y:   seg = GLYPH_Y;
          LTR_H:   seg = GLYPH_H;
          LTR_R:   seg = GLYPH_R;
          LTR_D:   seg = GLYPH_D;
          default: seg = GLYPH_BLANK;
        endcase
      end else begin
        case (code)
          4'd0:    seg = GLYPH_0;
          4'd1:    seg = GLYPH_1;
          4'd2:    seg = GLYPH_2;
          4'd3:    seg = GLYPH_3;
          4'd4:    seg = GLYPH_4;
          4'd5:    seg = GLYPH_5;
          4'd6:    seg = GLYPH_6;
          4'd7:    seg = GLYPH_7;
          4'd8:    seg = GLYPH_8;
          4'd9:    seg = GLYPH_9;
          default: seg = GLYPH_BLANK;
        endcase
      end
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Score-to-BCD converter (sequential double dabble), leading-zero blanking and a timed
// EASY/HARD banner that borrows all four HEX digits. dbg_state exposes the converter FSM.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int MSG_MS = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] score,
  input  logic        score_valid,
  output logic        score_ready,
  input  logic        difficulty,
  input  logic        diff_show,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        msg_mode,
  output conv_state_e dbg_state
);

  localparam int         MSG_CYC   = CLK_HZ / 1000 * MSG_MS;
  localparam int         CW        = cnt_width(MSG_CYC);
  localparam logic [3:0] ITER_LAST = 4'(BCD_ITER - 1);

  // Handshake: a score is taken on any rising edge where score_valid && score_ready;
  // score_valid while busy is dropped, never queued.
  conv_state_e    state_q, state_d;
  logic [13:0]    bin_q;
  logic [15:0]    bcd_q, bcd_adj, disp_q, disp_src;
  logic [3:0]     iter_q;
  logic [CW-1:0]  cnt_q;
  logic           diff_q, banner, accept;
  logic [13:0]    score_sat;
  logic [3:0][3:0] code_w;
  logic [3:0]     blk_w;
  logic [3:0][6:0] seg_w;

  assign score_ready = (state_q == ST_IDLE);
  assign accept      = score_valid && score_ready;
  assign dbg_state   = state_q;
  assign score_sat   = (score > 14'(SCORE_MAX)) ? 14'(SCORE_MAX) : score;
  assign banner      = (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SHIFT;
      ST_SHIFT:  if (iter_q == ITER_LAST) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            bin_q  <= score_sat;
            bcd_q  <= '0;
            iter_q <= '0;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          iter_q         <= iter_q + 4'd1;
        end
        ST_COMMIT: disp_q <= bcd_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      diff_q <= 1'b0;
    end else if (diff_show) begin
      cnt_q  <= CW'(MSG_CYC);
      diff_q <= difficulty;
    end else if (banner) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // The committing value feeds the output registers directly so the new score lands
  // on the same edge that the display register is written.
  assign disp_src = (state_q == ST_COMMIT) ? bcd_q : disp_q;

  always_comb begin
    code_w = disp_src;
    blk_w  = '0;
    if (banner) begin
      code_w = diff_q ? {LTR_H, LTR_A, LTR_R, LTR_D} : {LTR_E, LTR_A, LTR_S, LTR_Y};
    end else begin
      blk_w[3] = (disp_src[15:12] == 4'd0);
      blk_w[2] = blk_w[3] && (disp_src[11:8] == 4'd0);
      blk_w[1] = blk_w[2] && (disp_src[7:4] == 4'd0);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_glyph
    seg_glyph u_glyph (
      .is_letter (banner),
      .blank     (blk_w[g]),
      .code      (code_w[g]),
      .seg       (seg_w[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex0     <= GLYPH_0;
      hex1     <= GLYPH_BLANK;
      hex2     <= GLYPH_BLANK;
      hex3     <= GLYPH_BLANK;
      msg_mode <= 1'b0;
    end else begin
      hex0     <= seg_w[0];
      hex1     <= seg_w[1];
      hex2     <= seg_w[2];
      hex3     <= seg_w[3];
      msg_mode <= banner;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized scoreboard bench for seg_display_ctrl against a cycle-indexed reference model
// of score acceptance, commit timing, blanking, saturation and the difficulty banner.
module tb_seg_display_ctrl;
  import seg_display_pkg::*;

  localparam int CLK_HZ  = 1000;
  localparam int MSG_MS  = 5;
  localparam int MSG_CYC = 5;
  localparam int CONV    = 15;

  localparam logic [6:0]  BLK  = 7'b1111111;
  localparam logic [27:0] EASY = {7'b0000110, 7'b0001000, 7'b0010010, 7'b0010001};
  localparam logic [27:0] HARD = {7'b0001001, 7'b0001000, 7'b0101111, 7'b0100001};

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] score = '0;
  logic        score_valid = 1'b0;
  logic        difficulty = 1'b0;
  logic        diff_show = 1'b0;
  logic        score_ready, msg_mode;
  logic [6:0]  hex0, hex1, hex2, hex3;
  conv_state_e dbg_state;

  always #5 clk = ~clk;

  seg_display_ctrl #(.CLK_HZ(CLK_HZ), .MSG_MS(MSG_MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .score       (score),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .difficulty  (difficulty),
    .diff_show   (diff_show),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .msg_mode    (msg_mode),
    .dbg_state   (dbg_state)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  // reference model state
  logic [13:0] exp_q[$];
  int          acc_q[$];
  int          show_e[$];
  logic        show_d[$];
  int          busy_until = 0;
  int          last_acc = -100;
  int          shown = 0;
  logic        prev_ready = 1'b1;

  logic [6:0] dig_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [27:0] score_glyphs(int v);
    logic [6:0] h3, h2, h1, h0;
    h0 = dig_tbl[v % 10];
    h1 = (v < 10)   ? BLK : dig_tbl[(v / 10) % 10];
    h2 = (v < 100)  ? BLK : dig_tbl[(v / 100) % 10];
    h3 = (v < 1000) ? BLK : dig_tbl[(v / 1000) % 10];
    return {h3, h2, h1, h0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  // driver: call right after a negedge; inputs are sampled by the next rising edge
  task automatic drive(logic v, logic [13:0] s, logic ds, logic d);
    int e;
    e = edge_n + 1;
    score_valid = v;
    score       = s;
    diff_show   = ds;
    difficulty  = d;
    if (v && e >= busy_until) begin
      exp_q.push_back((s > 14'd9999) ? 14'd9999 : s);
      acc_q.push_back(e);
      last_acc   = e;
      busy_until = e + CONV + 1;
    end
    if (ds) begin
      show_e.push_back(e);
      show_d.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 14'($urandom), 1'b0, 1'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_hex", {hex3, hex2, hex1, hex0}, {BLK, BLK, BLK, 7'b1000000});
    check("rst_ready", score_ready, 1);
    check("rst_msg_mode", msg_mode, 0);
    exp_q.delete();
    acc_q.delete();
    show_e.delete();
    show_d.delete();
    shown      = 0;
    busy_until = 0;
    last_acc   = -100;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor / scoreboard: pops on each commit (score_ready rising), checks every cycle
  always @(negedge clk) begin : monitor
    int k, idx;
    logic exp_msg, exp_rdy;
    logic [27:0] exp_hex;
    k = edge_n;
    if (rst_n && mon_en) begin
      if (score_ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected at edge %0d: got commit expected none", k);
        end else begin
          shown = int'(exp_q.pop_front());
          check("commit_edge", k, acc_q.pop_front() + CONV);
        end
      end
      idx = -1;
      foreach (show_e[i]) if (show_e[i] < k) idx = i;
      exp_msg = 1'b0;
      if (idx >= 0) exp_msg = (k <= show_e[idx] + MSG_CYC);
      if (exp_msg) exp_hex = show_d[idx] ? HARD : EASY;
      else         exp_hex = score_glyphs(shown);
      exp_rdy = !(k >= last_acc && k <= last_acc + CONV - 1);
      check("msg_mode", msg_mode, exp_msg);
      check("hex", {hex3, hex2, hex1, hex0}, exp_hex);
      check("score_ready", score_ready, exp_rdy);
    end
    prev_ready = score_ready;
  end

  initial begin
    @(negedge clk);
    do_reset();
    mon_en = 1'b1;
    idle(3);

    drive(1'b1, 14'd1234, 1'b0, 1'b0);  idle(20);
    drive(1'b1, 14'd7, 1'b0, 1'b0);     idle(18);
    drive(1'b1, 14'd12000, 1'b0, 1'b0); idle(18);
    drive(1'b1, 14'd5, 1'b0, 1'b0);     idle(2);
    drive(1'b1, 14'd42, 1'b0, 1'b0);    idle(20);
    drive(1'b1, 14'd0, 1'b0, 1'b0);     idle(18);

    // HARD banner, then score returns
    drive(1'b0, 14'd0, 1'b1, 1'b1);     idle(10);
    // score committed while the banner is up
    drive(1'b1, 14'd321, 1'b0, 1'b0);   idle(10);
    drive(1'b0, 14'd0, 1'b1, 1'b1);     idle(12);
    // re-issue at banner cycle 3 switches to EASY and restarts the timer
    drive(1'b0, 14'd0, 1'b1, 1'b1);     idle(2);
    drive(1'b0, 14'd0, 1'b1, 1'b0);     idle(10);
    // simultaneous accept and banner
    drive(1'b1, 14'd8888, 1'b1, 1'b0);  idle(20);

    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 3) == 0), 14'($urandom_range(0, 16383)),
            ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end
    idle(20);

    // reset in the middle of a conversion: the partial result must never appear
    drive(1'b1, 14'd4321, 1'b0, 1'b0);  idle(5);
    do_reset();
    idle(20);
    drive(1'b1, 14'd90, 1'b0, 1'b0);    idle(20);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
